// File: rtl/mul_booth_seq_if.sv
// mul_booth_seq_if: request/response bundle between EX issue logic and the Booth multiplier.
// Revision: 1.0
`default_nettype none

interface mul_booth_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, rs1, rs2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, rs1, rs2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

`default_nettype wire

// File: rtl/mul_booth_seq.sv
// mul_booth_seq: iterative radix-8 Booth multiplier for MUL/MULH/MULHSU/MULHU, one window per cycle.
// Revision: 1.0
`default_nettype none

module mul_booth_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_booth_seq_if.slave bus
);
  localparam int AW   = XLEN + 1;
  localparam int ACCW = 2 * XLEN + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic [ACCW-1:0] acc;
  logic [AW-1:0]   a_ext;
  logic [AW-1:0]   b_ext;
  logic            hi_sel;

  logic            accept;
  logic            zero_op;
  logic            last_iter;
  logic            in_ready_c;
  logic            out_valid_c;
  logic            busy_c;

  assign accept    = (state == IDLE) && bus.in_valid && !bus.flush;
  assign zero_op   = (bus.rs1 == '0) || (bus.rs2 == '0);
  assign last_iter = (cnt == 4'(ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (accept) state_nxt = zero_op ? DONE : CALC;
      end
      CALC: begin
        if (bus.flush)      state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.flush || bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.result    = (state == DONE) ? (hi_sel ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]) : '0;

  // Window i covers b_ext[3i+2:3i-1]; the zero appended below supplies b_ext[-1].
  logic [AW:0]     b_pad;
  logic [5:0]      base;
  logic [3:0]      sel;
  logic [ACCW-1:0] a66;
  logic [ACCW-1:0] a3;
  logic [ACCW-1:0] mag;
  logic            neg;
  logic [ACCW-1:0] pp;
  logic [ACCW-1:0] pp_sh;

  assign b_pad = {b_ext, 1'b0};
  assign base  = {1'b0, cnt, 1'b0} + {2'b00, cnt};
  assign sel   = 4'(b_pad >> base);
  assign a66   = {{(ACCW-AW){a_ext[AW-1]}}, a_ext};
  assign a3    = a66 + (a66 << 1);

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (sel)
      4'b0001, 4'b0010: mag = a66;
      4'b0011, 4'b0100: mag = a66 << 1;
      4'b0101, 4'b0110: mag = a3;
      4'b0111:          mag = a66 << 2;
      4'b1000:          begin mag = a66 << 2; neg = 1'b1; end
      4'b1001, 4'b1010: begin mag = a3;       neg = 1'b1; end
      4'b1011, 4'b1100: begin mag = a66 << 1; neg = 1'b1; end
      4'b1101, 4'b1110: begin mag = a66;      neg = 1'b1; end
      default:          mag = '0;
    endcase
  end

  assign pp    = neg ? (~mag + 1'b1) : mag;
  assign pp_sh = pp << base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      a_ext  <= '0;
      b_ext  <= '0;
      hi_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_ext  <= {((bus.op == 2'b01) || (bus.op == 2'b10)) & bus.rs1[XLEN-1], bus.rs1};
            b_ext  <= {(bus.op == 2'b01) & bus.rs2[XLEN-1], bus.rs2};
            hi_sel <= (bus.op != 2'b00);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc <= acc + pp_sh;
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Bits above the 64-bit product only absorb sign carries and never reach the result.
  logic unused_acc_top;
  assign unused_acc_top = ^acc[ACCW-1:2*XLEN];

endmodule

`default_nettype wire

// File: tb/tb_mul_booth_seq.sv
// Directed and randomized scoreboard bench for mul_booth_seq.
`default_nettype none

module tb_mul_booth_seq;
  logic clk;
  logic rst_n;

  mul_booth_seq_if #(.XLEN(32)) bus ();

  mul_booth_seq #(.XLEN(32), .ITERS(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = ((op == 2'b01) || (op == 2'b10)) ? {{34{a[31]}}, a} : {34'b0, a};
    sb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: every completed transfer pops one expected word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=0x%08h expected=none", bus.result);
      end else begin
        chk("result", bus.result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit push);
    int tmo;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rs1      = a;
    bus.rs2      = b;
    tmo = 0;
    while (!bus.in_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 100) chk("accept_timeout", 32'(tmo), 32'd0);
    @(posedge clk);
    if (push) exp_q.push_back(expv);
    #1;
    bus.in_valid = 1'b0;
    bus.rs1      = $urandom;
    bus.rs2      = $urandom;
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    int tmo;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    tmo = 0;
    while (bus.out_valid && tmo < 100) begin
      @(posedge clk); #1;
      tmo++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input int exp_lat);
    issue(op, a, b, expv, 1'b1);
    wait_done(exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 11);
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 11);
    run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 11);
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 11);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 11);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 11);
    run_op(2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 0);

    // Requests held during CALC/DONE must be refused.
    issue(2'b00, 32'd3, 32'd4, 32'd12, 1'b1);
    bus.in_valid = 1'b1;
    bus.op       = 2'b01;
    bus.rs1      = 32'hAAAAAAAA;
    bus.rs2      = 32'h55555555;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      chk("calc_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      k++;
    end
    chk("calc_latency", 32'(k), 32'd11);
    chk("done_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure then back-to-back request.
    bus.out_ready = 1'b0;
    issue(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", 32'(k), 32'd11);
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_result", bus.result, 32'h00000001);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    run_op(2'b00, 32'd100, 32'd200, 32'd20000, 11);

    // Flush at iteration 5.
    issue(2'b00, 32'd5, 32'd5, 32'd25, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_busy_before", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_busy", {31'b0, bus.busy}, 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
      chk("flush_no_valid", {31'b0, bus.out_valid}, 32'd0);
    end
    run_op(2'b00, 32'd5, 32'd5, 32'd25, 11);

    // Flush wins over a completing transfer in DONE.
    bus.out_ready = 1'b0;
    issue(2'b00, 32'd0, 32'd9, 32'd0, 1'b0);
    chk("flushdone_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flushdone_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flushdone_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Asynchronous reset mid-CALC.
    issue(2'b01, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b11, 32'hDEADBEEF, 32'h00000010, 32'h0000000D, 11);

    for (int i = 0; i < 400; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 8 == 1) ra = {ra[31], 31'b0};
      if (i % 8 == 3) rb = 32'hFFFFFFFF;
      if (i % 16 == 5) ra = 32'd0;
      if (i % 16 == 9) rb = 32'd0;
      run_op(rop, ra, rb, ref_mul(rop, ra, rb), (ra == 0 || rb == 0) ? 0 : 11);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
